if_prefetch_unit: RTL

//  Parametrised instruction-fetch stage for the RV32IM core.
//  - Generates sequential fetch PCs and handles branch and jump redirects.
//  - Issues requests to instruction memory over a valid/ready handshake; memory responses return in order.
//  - Buffers fetched instructions in a DEPTH-entry prefetch FIFO.
//  - Delivers {inst, inst_pc} to decode over a valid/ready handshake.
//  - Sits between the PC-redirect logic (ID jump, EX branch) and the ID stage.

---
 rtl/rv_if_pkg.sv | 14 +
 rtl/if_sync_fifo.sv | 48 ++++
 rtl/if_prefetch_unit.sv | 80 ++++++++
 3 files changed

// File: rtl/rv_if_pkg.sv
// rv_if_pkg: shared constants, fetch entry type and PC alignment helper for the fetch stage.
package rv_if_pkg;
  localparam int ILEN = 32;
  localparam int PC_W = 32;
  localparam int PC_STEP = 4;
  localparam logic [ILEN-1:0] NOP_INST = 32'h0000_0013;
  typedef struct packed {
    logic [ILEN-1:0] inst;
    logic [PC_W-1:0] pc;
  } fetch_entry_t;
  function automatic logic [PC_W-1:0] align_pc(input logic [PC_W-1:0] pc);
    return {pc[PC_W-1:2], 2'b00};
  endfunction
endpackage

// File: rtl/if_sync_fifo.sv
// if_sync_fifo: synchronous FIFO with flush and occupancy count; push while full is legal only alongside a pop.
module if_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       flush_i,
  input  logic                       push_i,
  input  logic                       pop_i,
  input  logic [WIDTH-1:0]           wdata_i,
  output logic [WIDTH-1:0]           rdata_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       full_o,
  output logic                       empty_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  assign empty_o = count_q == '0;
  assign full_o = count_q == CW'(DEPTH);
  assign do_pop = pop_i && !empty_o;
  assign do_push = push_i && (!full_o || do_pop);
  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  always_comb begin
    wr_ptr_d = flush_i ? '0 : wr_ptr_q + AW'(do_push);
    rd_ptr_d = flush_i ? '0 : rd_ptr_q + AW'(do_pop);
    count_d = flush_i ? '0 : count_q + CW'(do_push) - CW'(do_pop);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q <= count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (do_push && !flush_i) mem_q[wr_ptr_q] <= wdata_i;
  end
endmodule

// File: rtl/if_prefetch_unit.sv
// if_prefetch_unit: RV32 fetch stage issuing in-order imem requests into a credit-limited prefetch FIFO.
// Stale responses after a redirect are counted out with a drop counter instead of being tagged.
module if_prefetch_unit
  import rv_if_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              DEPTH    = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            branch_taken,
  input  logic [XLEN-1:0] branch_target,
  input  logic            jump_taken,
  input  logic [XLEN-1:0] jump_target,
  output logic            imem_req_valid,
  input  logic            imem_req_ready,
  output logic [XLEN-1:0] imem_req_addr,
  input  logic            imem_rsp_valid,
  input  logic [ILEN-1:0] imem_rsp_data,
  output logic            inst_valid,
  input  logic            inst_ready,
  output logic [ILEN-1:0] inst,
  output logic [XLEN-1:0] inst_pc
);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d, target;
  logic [CW-1:0] outst_q, outst_d, drop_q, drop_d, count;
  logic [CW:0] inflight;
  logic redirect, accept, push, pop, full, empty;
  fetch_entry_t wr_entry, rd_entry;
  assign redirect = branch_taken | jump_taken;
  assign target = align_pc(branch_taken ? branch_target : jump_target);
  // Buffered plus in-flight words never exceed DEPTH, so every response has a FIFO slot.
  assign inflight = {1'b0, count} + {1'b0, outst_q};
  assign imem_req_valid = reset && !redirect && (inflight < (CW+1)'(DEPTH));
  assign imem_req_addr = fetch_pc_q;
  assign accept = imem_req_valid && imem_req_ready;
  assign push = imem_rsp_valid && !redirect && drop_q == '0;
  assign inst_valid = reset && !empty && !redirect;
  assign pop = inst_valid && inst_ready;
  assign inst = inst_valid ? rd_entry.inst : NOP_INST;
  assign inst_pc = inst_valid ? rd_entry.pc : '0;
  assign wr_entry = '{inst: imem_rsp_data, pc: rsp_pc_q};
  always_comb begin
    fetch_pc_d = redirect ? target : accept ? fetch_pc_q + XLEN'(PC_STEP) : fetch_pc_q;
    rsp_pc_d = redirect ? target : push ? rsp_pc_q + XLEN'(PC_STEP) : rsp_pc_q;
    outst_d = outst_q + CW'(accept) - CW'(imem_rsp_valid && outst_q != '0);
    drop_d = redirect ? outst_q - CW'(imem_rsp_valid && outst_q != '0)
                      : drop_q - CW'(imem_rsp_valid && drop_q != '0);
  end
  always_ff @(posedge clk) begin
    if (!reset) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q <= RESET_PC;
      outst_q <= '0;
      drop_q <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q <= rsp_pc_d;
      outst_q <= outst_d;
      drop_q <= drop_d;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) assert (!(push && full && !pop));
  end
  if_sync_fifo #(.WIDTH($bits(fetch_entry_t)), .DEPTH(DEPTH)) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .flush_i (redirect),
    .push_i  (push),
    .pop_i   (pop),
    .wdata_i (wr_entry),
    .rdata_o (rd_entry),
    .count_o (count),
    .full_o  (full),
    .empty_o (empty)
  );
endmodule
